// File: rtl/pipelined_instr_decode.sv
// ---------------------------------------------------------------------------
// pipelined_instr_decode
//   ID-stage MIPS instruction decoder with a valid/ready handshake.
//   Each accepted instruction is split into its fields, classified as
//   R/I/J, has its immediate extended to XLEN and its jump target formed.
//   All of that is registered, so out_* never depends combinationally on
//   in_instr_i. With SKID=1 a second entry catches the instruction that
//   arrives while the output is stalled, letting in_ready_o come from a flop.
//
// Ports:
//   clk_i              system clock, rising edge
//   reset_n_i          synchronous reset, active low
//   flush_i            discard every held instruction (redirect)
//   in_valid_i         fetch presents an instruction
//   in_ready_o         decoder accepts in_instr_i this cycle
//   in_instr_i [31:0]  raw instruction word
//   in_pc_i    [XLEN]  PC of in_instr_i
//   out_valid_o        decoded fields valid
//   out_ready_i        downstream accepts this cycle
//   out_opcode_o .. out_funct_o, out_address_o   instruction fields
//   out_imm_ext_o      extended immediate
//   out_jump_target_o  {pc_plus4[XLEN-1:28], address, 2'b00}
//   out_type_o         00 = R, 01 = I, 10 = J
//   out_pc_o           PC of the decoded instruction
// ---------------------------------------------------------------------------
module pipelined_instr_decode #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [5:0]      out_opcode_o,
  output logic [4:0]      out_rs_o,
  output logic [4:0]      out_rt_o,
  output logic [4:0]      out_rd_o,
  output logic [4:0]      out_shamt_o,
  output logic [5:0]      out_funct_o,
  output logic [25:0]     out_address_o,
  output logic [XLEN-1:0] out_imm_ext_o,
  output logic [XLEN-1:0] out_jump_target_o,
  output logic [1:0]      out_type_o,
  output logic [XLEN-1:0] out_pc_o
);

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] immExt;
    logic [XLEN-1:0] jumpTarget;
    logic [1:0]      instrType;
  } entry_t;

  state_e          state_q;
  entry_t          outEntry_q;
  entry_t          skidEntry_q;
  logic            outValid_q;
  logic            ready_q;
  entry_t          decoded_d;

  logic [5:0]      opcode;
  logic [15:0]     imm16;
  logic [XLEN-1:0] pcPlus4;
  logic            inXfer;
  logic            outXfer;

  assign opcode  = in_instr_i[31:26];
  assign imm16   = in_instr_i[15:0];
  assign pcPlus4 = in_pc_i + XLEN'(4);

  // Decode the incoming word into a full output entry so that both the
  // output register and the skid entry hold ready-to-present values.
  // The lui case sign-extends imm16 and then shifts, which is the same as
  // sign-extending {imm16, 16'h0} from bit 31. The jump target keeps the
  // top bits of pc+4 by masking rather than slicing.
  always_comb begin
    decoded_d       = '0;
    decoded_d.instr = in_instr_i;
    decoded_d.pc    = in_pc_i;

    if (opcode == 6'h00)
      decoded_d.instrType = TYPE_R;
    else if (opcode == 6'h02 || opcode == 6'h03)
      decoded_d.instrType = TYPE_J;
    else
      decoded_d.instrType = TYPE_I;

    case (opcode)
      6'h0C, 6'h0D, 6'h0E: decoded_d.immExt = {{(XLEN-16){1'b0}}, imm16};
      6'h0F:               decoded_d.immExt = {{(XLEN-16){imm16[15]}}, imm16} << 16;
      default:             decoded_d.immExt = {{(XLEN-16){imm16[15]}}, imm16};
    endcase

    decoded_d.jumpTarget = (pcPlus4 & ~XLEN'(32'h0FFF_FFFF))
                         | XLEN'({in_instr_i[25:0], 2'b00});
  end

  // Reset and flush both force in_ready low in their own cycle. With the
  // skid buffer the ready term is a flop; without it, the single output
  // register can take a new word whenever it is empty or being drained.
  assign in_ready_o = reset_n_i && !flush_i &&
                      ((SKID != 0) ? ready_q : (!outValid_q || out_ready_i));
  assign inXfer     = in_valid_i && in_ready_o;
  assign outXfer    = outValid_q && out_ready_i;

  // Occupancy FSM. Without the skid buffer an input transfer in ONE always
  // coincides with an output transfer, so TWO is never entered and the same
  // FSM serves both builds. Flush only clears the valid/occupancy state;
  // the field values left behind are don't-care while out_valid is low.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= EMPTY;
      outEntry_q  <= '0;
      skidEntry_q <= '0;
      outValid_q  <= 1'b0;
      ready_q     <= 1'b1;
    end else if (flush_i) begin
      state_q    <= EMPTY;
      outValid_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (inXfer) begin
            outEntry_q <= decoded_d;
            outValid_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            outEntry_q <= decoded_d;
          end else if (inXfer) begin
            skidEntry_q <= decoded_d;
            ready_q     <= 1'b0;
            state_q     <= TWO;
          end else if (outXfer) begin
            outValid_q <= 1'b0;
            state_q    <= EMPTY;
          end
        end
        TWO: begin
          if (outXfer) begin
            outEntry_q <= skidEntry_q;
            ready_q    <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= EMPTY;
        end
      endcase
    end
  end

  assign out_valid_o       = outValid_q;
  assign out_opcode_o      = outEntry_q.instr[31:26];
  assign out_rs_o          = outEntry_q.instr[25:21];
  assign out_rt_o          = outEntry_q.instr[20:16];
  assign out_rd_o          = outEntry_q.instr[15:11];
  assign out_shamt_o       = outEntry_q.instr[10:6];
  assign out_funct_o       = outEntry_q.instr[5:0];
  assign out_address_o     = outEntry_q.instr[25:0];
  assign out_imm_ext_o     = outEntry_q.immExt;
  assign out_jump_target_o = outEntry_q.jumpTarget;
  assign out_type_o        = outEntry_q.instrType;
  assign out_pc_o          = outEntry_q.pc;

endmodule

// File: tb/tb_pipelined_instr_decode.sv
// ---------------------------------------------------------------------------
// tb_pipelined_instr_decode
//   Scoreboard bench for pipelined_instr_decode (XLEN=32, SKID=1).
//   Stimulus pushes hand-computed expected decodes when an instruction is
//   accepted; a monitor pops and compares on every output transfer and
//   checks that a stalled output holds still.
// ---------------------------------------------------------------------------
module tb_pipelined_instr_decode;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [25:0] addr;
    logic [31:0] imm;
    logic [31:0] jt;
    logic [1:0]  typ;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [25:0] out_address;
  logic [31:0] out_imm_ext;
  logic [31:0] out_jump_target;
  logic [1:0]  out_type;
  logic [31:0] out_pc;

  int          total = 0;
  int          bad = 0;
  vec_t        vecs[9];
  vec_t        expQ[$];
  vec_t        monE;
  logic [159:0] snapNow;
  logic [159:0] holdSnap;
  bit          holdArmed = 1'b0;

  pipelined_instr_decode #(.XLEN(32), .SKID(1)) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .flush_i           (flush),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_instr_i        (in_instr),
    .in_pc_i           (in_pc),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .out_opcode_o      (out_opcode),
    .out_rs_o          (out_rs),
    .out_rt_o          (out_rt),
    .out_rd_o          (out_rd),
    .out_shamt_o       (out_shamt),
    .out_funct_o       (out_funct),
    .out_address_o     (out_address),
    .out_imm_ext_o     (out_imm_ext),
    .out_jump_target_o (out_jump_target),
    .out_type_o        (out_type),
    .out_pc_o          (out_pc)
  );

  always #5 clk = ~clk;

  assign snapNow = {4'b0, out_pc, out_imm_ext, out_jump_target, out_address,
                    out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_type};

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Present one vector and hold it until accepted; the expected decode is
  // queued in the same cycle the handshake completes.
  task automatic applyStimulus(input int idx);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_pc    = vecs[idx].pc;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(vecs[idx]);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: vector %0d got no in_ready, required acceptance", idx);
    end
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 100 && expQ.size() != 0; c++) @(negedge clk);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: %0d entries left, required 0", expQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every output transfer against the scoreboard head and
  // checks that a stalled output stays bit-stable into the next cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && holdArmed) checkOutput("hold", snapNow, holdSnap);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got pc=%0h instr-op=%0h, required no output", out_pc, out_opcode);
        end else begin
          monE = expQ.pop_front();
          checkOutput("opcode",      160'(out_opcode),      160'(monE.opc));
          checkOutput("rs",          160'(out_rs),          160'(monE.rs));
          checkOutput("rt",          160'(out_rt),          160'(monE.rt));
          checkOutput("rd",          160'(out_rd),          160'(monE.rd));
          checkOutput("shamt",       160'(out_shamt),       160'(monE.sh));
          checkOutput("funct",       160'(out_funct),       160'(monE.fn));
          checkOutput("address",     160'(out_address),     160'(monE.addr));
          checkOutput("imm_ext",     160'(out_imm_ext),     160'(monE.imm));
          checkOutput("jump_target", 160'(out_jump_target), 160'(monE.jt));
          checkOutput("type",        160'(out_type),        160'(monE.typ));
          checkOutput("pc",          160'(out_pc),          160'(monE.pc));
        end
      end
      holdArmed = out_valid && !out_ready;
      holdSnap  = snapNow;
    end else begin
      holdArmed = 1'b0;
    end
  end

  initial begin
    //              instr         pc            opc    rs     rt     rd     sh     fn     addr          imm           jt            typ
    vecs[0] = '{32'h00000000, 32'h00000000, 6'h00, 5'h00, 5'h00, 5'h00, 5'h00, 6'h00, 26'h0000000, 32'h00000000, 32'h00000000, 2'b00};
    vecs[1] = '{32'h01782020, 32'h00400000, 6'h00, 5'h0B, 5'h18, 5'h04, 5'h00, 6'h20, 26'h1782020, 32'h00002020, 32'h05E08080, 2'b00};
    vecs[2] = '{32'h2008FFFF, 32'h00400004, 6'h08, 5'h00, 5'h08, 5'h1F, 5'h1F, 6'h3F, 26'h008FFFF, 32'hFFFFFFFF, 32'h0023FFFC, 2'b01};
    vecs[3] = '{32'h3408FFFF, 32'h00400008, 6'h0D, 5'h00, 5'h08, 5'h1F, 5'h1F, 6'h3F, 26'h008FFFF, 32'h0000FFFF, 32'h0023FFFC, 2'b01};
    vecs[4] = '{32'h3C081234, 32'h0040000C, 6'h0F, 5'h00, 5'h08, 5'h02, 5'h08, 6'h34, 26'h0081234, 32'h12340000, 32'h002048D0, 2'b01};
    vecs[5] = '{32'h08000010, 32'h00400000, 6'h02, 5'h00, 5'h00, 5'h00, 5'h00, 6'h10, 26'h0000010, 32'h00000010, 32'h00000040, 2'b10};
    vecs[6] = '{32'h3C088000, 32'hFFFFFFFC, 6'h0F, 5'h00, 5'h08, 5'h10, 5'h00, 6'h00, 26'h0088000, 32'h80000000, 32'h00220000, 2'b01};
    vecs[7] = '{32'h31088001, 32'hEFFFFFFC, 6'h0C, 5'h08, 5'h08, 5'h10, 5'h00, 6'h01, 26'h1088001, 32'h00008001, 32'hF4220004, 2'b01};
    vecs[8] = '{32'h0C000001, 32'h10000000, 6'h03, 5'h00, 5'h00, 5'h00, 5'h00, 6'h01, 26'h0000001, 32'h00000001, 32'h10000004, 2'b10};

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_in_ready", 160'(in_ready), 160'(0));
    checkOutput("reset_out_valid", 160'(out_valid), 160'(0));
    checkOutput("reset_fields", snapNow, 160'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 160'(in_ready), 160'(1));
    @(posedge clk);
    #1;

    // NOP with one-cycle latency, then the full table back to back
    $display("[TB] directed decode vectors");
    out_ready = 1'b1;
    applyStimulus(0);
    @(negedge clk);
    checkOutput("latency_valid", 160'(out_valid), 160'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) applyStimulus(i);
    waitDrain();

    // Backpressure: A and B fill both entries, C waits for space
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(1);
    applyStimulus(2);
    fork
      applyStimulus(3);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 160'(in_ready), 160'(0));
          checkOutput("stall_out_valid", 160'(out_valid), 160'(1));
          checkOutput("stall_out_pc", 160'(out_pc), 160'(vecs[1].pc));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Flush with two entries held; the flush-cycle word must be dropped
    $display("[TB] flush");
    out_ready = 1'b0;
    applyStimulus(1);
    applyStimulus(2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = vecs[3].instr;
    in_pc    = vecs[3].pc;
    @(negedge clk);
    checkOutput("flush_in_ready", 160'(in_ready), 160'(0));
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("post_flush_valid", 160'(out_valid), 160'(0));
    checkOutput("post_flush_ready", 160'(in_ready), 160'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("flush_dropped", 160'(out_valid), 160'(0));
    end
    @(posedge clk);
    #1;

    // Flush while one entry drains in the same cycle: that one is consumed
    out_ready = 1'b0;
    applyStimulus(4);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = vecs[5].instr;
    in_pc     = vecs[5].pc;
    @(negedge clk);
    checkOutput("flush_one_in_ready", 160'(in_ready), 160'(0));
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("flush_one_valid", 160'(out_valid), 160'(0));
    end
    @(posedge clk);
    #1;

    // Reset in the middle of a stream
    $display("[TB] mid-stream reset");
    out_ready = 1'b0;
    applyStimulus(6);
    applyStimulus(7);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_instr = vecs[8].instr;
    in_pc    = vecs[8].pc;
    @(negedge clk);
    checkOutput("midreset_in_ready", 160'(in_ready), 160'(0));
    @(posedge clk);
    #1;
    expQ.delete();
    @(negedge clk);
    checkOutput("midreset_valid", 160'(out_valid), 160'(0));
    checkOutput("midreset_fields", snapNow, 160'(0));
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midreset_release_ready", 160'(in_ready), 160'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(8);
    applyStimulus(0);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_instr_decode.md
Name: pipelined_instr_decode

Overview:
- Next-generation MIPS instruction decoder for the ID stage, sitting between the fetch unit and the register file / ALU control.
- Registers one 32-bit instruction per transfer and splits it into fields.
- Also classifies the format (R/I/J), extends the immediate to XLEN and forms the jump target.
- Adds a valid/ready handshake, an optional skid buffer and a pipeline flush, none of which the single-register decoder has.

Parameters:
- XLEN, 32: width of the PC, the extended immediate and the jump target; legal values are ≥32.
- SKID, 1: 1 builds a 2-entry skid buffer so in_ready is driven straight from a flop; 0 builds a single output register with a combinational in_ready.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- flush  in  1  kills every held instruction (branch or jump redirect).
- in_valid  in  1  fetch is presenting an instruction.
- in_ready  out  1  the block will accept in_instr this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  the downstream stage accepts this cycle.
- out_opcode  out  6  instr[31:26].
- out_rs  out  5  instr[25:21].
- out_rt  out  5  instr[20:16].
- out_rd  out  5  instr[15:11].
- out_shamt  out  5  instr[10:6].
- out_funct  out  6  instr[5:0].
- out_address  out  26  instr[25:0].
- out_imm_ext  out  XLEN  extended immediate (rules below).
- out_jump_target  out  XLEN  {pc_plus4[XLEN-1:28], address, 2'b00}.
- out_type  out  2  00 = R, 01 = I, 10 = J.
- out_pc  out  XLEN  PC of the decoded instruction.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - out_valid = 0; all out_* fields = 0; skid buffer empty.
  - in_ready = 0 while reset_n is low, 1 on the first cycle after release.
- Transfers:
  - An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
  - Latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N.
- Output hold: while out_valid && !out_ready, every out_* signal stays bit-stable.
- Decode is fully registered; no output depends combinationally on in_instr.
- out_type:
  - opcode 0x00 gives R.
  - opcode 0x02 or 0x03 gives J.
  - every other opcode gives I.
- out_imm_ext:
  - opcodes 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extend imm16.
  - opcode 0x0F (lui): {imm16, 16'h0}, then sign-extended from bit 31 to XLEN.
  - all other opcodes: sign-extend imm16.
  - The value is computed for every instruction, whatever its type.
- out_jump_target: pc_plus4 = in_pc + 4, computed mod 2^XLEN. Wrap from all-ones to 0 is legal.
- SKID = 0:
  - in_ready = !out_valid || out_ready (combinational).
- SKID = 1, states EMPTY (out reg empty), ONE (out reg full), TWO (out reg + skid full); in_ready = (state != TWO), registered.
  - EMPTY→ONE on an input transfer.
  - ONE→EMPTY on an output transfer with no input transfer.
  - ONE→ONE when input and output transfer together (the output register reloads).
  - ONE→TWO on an input transfer while the output is stalled; the input goes into the skid entry.
  - TWO→ONE on an output transfer; the skid entry moves to the output register.
  - Order is strictly FIFO; no instruction is ever dropped or duplicated.
- Flush:
  - Takes priority over everything except reset.
  - Forces in_ready = 0 in the flush cycle; any in_valid that cycle is not accepted.
  - At the edge: out_valid = 0, skid emptied, state = EMPTY; field values are don't-care but must not glitch out_valid.
  - in_ready = 1 in the cycle after flush deasserts.
- Flush and output transfer in the same cycle: the output transfer still counts as consumed by downstream.
- Reset in mid-operation behaves exactly like the reset values above and discards all held instructions.

Test Plan:
- Reset then in_instr = 32'h0 (NOP), out_ready = 1: after 1 cycle out_valid = 1, all fields 0, out_type = 00, out_imm_ext = 0.
- 32'h01782020 (add) → opcode 0x00, rs 0x0B, rt 0x18, rd 0x04, shamt 0, funct 0x20, type R. Then 32'h2008FFFF (addi) → rt 0x08, imm_ext 0xFFFFFFFF, type I.
- Immediate extension: 32'h3408FFFF (ori) → imm_ext 0x0000FFFF; 32'h3C081234 (lui) → imm_ext 0x12340000.
- Jump target: 32'h08000010 with in_pc = 0x00400000 → type J, address 0x0000010, jump_target 0x00000040.
- Backpressure with SKID = 1:
  - Hold out_ready = 0 and stream A, B, C: A and B are accepted, in_ready falls to 0 while in TWO, outputs stay on A.
  - Release out_ready: A, B, C emerge in order, one per cycle, with no loss.
- Flush: with two entries held, pulse flush for 1 cycle while in_valid = 1 → next cycle out_valid = 0, the flush-cycle input is not accepted, and in_ready = 1. Drive reset_n = 0 in the middle of a stream → out_valid = 0 and all fields 0 at the next edge.
